// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - pipelined FP32 adder/subtractor with valid/ready flow control and tag passthrough
//
// Logical stages: unpack/compare | align+add | normalise | round/pack.
// NSTAGE (1..4) registers are placed from the output backwards; the
// boundaries that are not registered become plain wires.
// Denormal inputs are flushed to signed zero and tiny results flush to zero.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake for x1, x2, sub, in_tag
//   x1, x2                    IEEE-754 single operands
//   sub                       0: y = x1 + x2, 1: y = x1 - x2
//   in_tag                    opaque tag, returned unchanged on out_tag
//   out_valid/out_ready       output handshake for y, ovf, nan, out_tag
//   y                         result
//   ovf                       finite inputs overflowed to infinity
//   nan                       result is the canonical NaN 0x7FC00000
//   out_tag                   tag of the operation producing y
module fadd_pipe #(
  parameter int NSTAGE = 4,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     x1,
  input  logic [31:0]     x2,
  input  logic            sub,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     y,
  output logic            ovf,
  output logic            nan,
  output logic [TAGW-1:0] out_tag
);

  // Unpacked and ordered operands: big has the larger magnitude.
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic            is_nan;
    logic            is_inf;
    logic            inf_sign;
    logic            sign;
    logic            eff_sub;
    logic [7:0]      big_e;
    logic [23:0]     big_m;
    logic [23:0]     small_m;
    logic [7:0]      shift;
  } s1_t;

  // Raw 28-bit magnitude sum: [27] carry, [26] hidden, [2:0] guard/round/sticky.
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic            is_nan;
    logic            is_inf;
    logic            inf_sign;
    logic            sign;
    logic            eff_sub;
    logic [7:0]      big_e;
    logic [27:0]     sum;
  } s2_t;

  // Normalised mantissa with hidden bit at [26]; exp is two's complement.
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic            is_nan;
    logic            is_inf;
    logic            inf_sign;
    logic            sign;
    logic            zero;
    logic [9:0]      exp;
    logic [26:0]     mant;
  } s3_t;

  logic advance;
  s1_t  s1_c, s1_q;
  s2_t  s2_c, s2_q;
  s3_t  s3_c, s3_q;

  // The whole pipe moves as one; it only holds when the result is refused.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // ---------------------------------------------------------------- unpack
  logic        a_s, b_s;
  logic [7:0]  a_e, b_e, small_e;
  logic [22:0] a_f, b_f;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] a_m, b_m;
  logic [30:0] a_mag, b_mag;
  logic        swap;

  always_comb begin
    a_s    = x1[31];
    a_e    = x1[30:23];
    a_f    = x1[22:0];
    b_s    = x2[31] ^ sub;
    b_e    = x2[30:23];
    b_f    = x2[22:0];
    a_zero = (a_e == 8'd0);
    b_zero = (b_e == 8'd0);
    a_inf  = (a_e == 8'hFF) && (a_f == 23'd0);
    b_inf  = (b_e == 8'hFF) && (b_f == 23'd0);
    a_nan  = (a_e == 8'hFF) && (a_f != 23'd0);
    b_nan  = (b_e == 8'hFF) && (b_f != 23'd0);
    // Flushed operands carry no mantissa so they compare as true zero.
    a_m    = a_zero ? 24'd0 : {1'b1, a_f};
    b_m    = b_zero ? 24'd0 : {1'b1, b_f};
    a_mag  = a_zero ? 31'd0 : {a_e, a_f};
    b_mag  = b_zero ? 31'd0 : {b_e, b_f};
    swap   = (b_mag > a_mag);
    small_e = swap ? a_e : b_e;

    s1_c          = '0;
    s1_c.valid    = in_valid;
    s1_c.tag      = in_tag;
    s1_c.is_nan   = a_nan | b_nan | (a_inf & b_inf & (a_s ^ b_s));
    s1_c.is_inf   = a_inf | b_inf;
    s1_c.inf_sign = a_inf ? a_s : b_s;
    s1_c.sign     = swap ? b_s : a_s;
    s1_c.eff_sub  = a_s ^ b_s;
    s1_c.big_e    = swap ? b_e : a_e;
    s1_c.big_m    = swap ? b_m : a_m;
    s1_c.small_m  = swap ? a_m : b_m;
    s1_c.shift    = s1_c.big_e - small_e;
  end

  // ------------------------------------------------------------- align+add
  logic [26:0] small_ext, aligned, lost_mask;
  logic        sticky;
  logic [27:0] big_ext;

  always_comb begin
    small_ext = {s1_q.small_m, 3'b000};
    if (s1_q.shift >= 8'd27) begin
      aligned   = 27'd0;
      lost_mask = '1;
      sticky    = |s1_q.small_m;
    end else begin
      aligned   = small_ext >> s1_q.shift;
      lost_mask = (27'd1 << s1_q.shift) - 27'd1;
      sticky    = |(small_ext & lost_mask);
    end
    // Jam the shifted-out bits into the LSB so RNE sees them as sticky.
    aligned[0] = aligned[0] | sticky;
    big_ext    = {1'b0, s1_q.big_m, 3'b000};

    s2_c          = '0;
    s2_c.valid    = s1_q.valid;
    s2_c.tag      = s1_q.tag;
    s2_c.is_nan   = s1_q.is_nan;
    s2_c.is_inf   = s1_q.is_inf;
    s2_c.inf_sign = s1_q.inf_sign;
    s2_c.sign     = s1_q.sign;
    s2_c.eff_sub  = s1_q.eff_sub;
    s2_c.big_e    = s1_q.big_e;
    // big >= small in magnitude, so the difference never goes negative.
    s2_c.sum      = s1_q.eff_sub ? (big_ext - {1'b0, aligned})
                                 : (big_ext + {1'b0, aligned});
  end

  // ------------------------------------------------------------- normalise
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [4:0] lz;

  always_comb begin
    lz = lzc27(s2_q.sum[26:0]);

    s3_c          = '0;
    s3_c.valid    = s2_q.valid;
    s3_c.tag      = s2_q.tag;
    s3_c.is_nan   = s2_q.is_nan;
    s3_c.is_inf   = s2_q.is_inf;
    s3_c.inf_sign = s2_q.inf_sign;
    s3_c.zero     = (s2_q.sum == 28'd0);
    // Exact cancellation gives +0; a sum of like-signed zeros keeps the sign.
    s3_c.sign     = (s3_c.zero && s2_q.eff_sub) ? 1'b0 : s2_q.sign;
    if (s2_q.sum[27]) begin
      s3_c.mant = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      s3_c.exp  = {2'b00, s2_q.big_e} + 10'd1;
    end else begin
      s3_c.mant = s2_q.sum[26:0] << lz;
      s3_c.exp  = {2'b00, s2_q.big_e} - {5'd0, lz};
    end
  end

  // ------------------------------------------------------------ round/pack
  logic        rnd_up;
  logic [24:0] m_rnd;
  logic [9:0]  exp_rnd;
  logic [31:0] y_c;
  logic        ovf_c, nan_c;

  always_comb begin
    rnd_up  = s3_q.mant[2] & (s3_q.mant[1] | s3_q.mant[0] | s3_q.mant[3]);
    m_rnd   = {1'b0, s3_q.mant[26:3]} + {24'd0, rnd_up};
    // Mantissa carry-out: value is exactly 2.0 * 2^exp, fraction becomes 0.
    exp_rnd = s3_q.exp + {9'd0, m_rnd[24]};
    y_c     = {s3_q.sign, 31'd0};
    ovf_c   = 1'b0;
    nan_c   = 1'b0;
    if (s3_q.is_nan) begin
      y_c   = 32'h7FC0_0000;
      nan_c = 1'b1;
    end else if (s3_q.is_inf) begin
      y_c = {s3_q.inf_sign, 8'hFF, 23'd0};
    end else if (s3_q.zero || ($signed(s3_q.exp) <= 10'sd0)) begin
      y_c = {s3_q.sign, 31'd0};
    end else if ($signed(exp_rnd) >= 10'sd255) begin
      y_c   = {s3_q.sign, 8'hFF, 23'd0};
      ovf_c = 1'b1;
    end else begin
      y_c = {s3_q.sign, exp_rnd[7:0], m_rnd[24] ? 23'd0 : m_rnd[22:0]};
    end
  end

  // --------------------------------------------------- stage boundaries
  generate
    if (NSTAGE >= 4) begin : g_reg1
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        s1_q <= '0;
        else if (advance) s1_q <= s1_c;
      end
    end else begin : g_wire1
      assign s1_q = s1_c;
    end

    if (NSTAGE >= 3) begin : g_reg2
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        s2_q <= '0;
        else if (advance) s2_q <= s2_c;
      end
    end else begin : g_wire2
      assign s2_q = s2_c;
    end

    if (NSTAGE >= 2) begin : g_reg3
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        s3_q <= '0;
        else if (advance) s3_q <= s3_c;
      end
    end else begin : g_wire3
      assign s3_q = s3_c;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      ovf       <= 1'b0;
      nan       <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= s3_q.valid;
      y         <= y_c;
      ovf       <= ovf_c;
      nan       <= nan_c;
      out_tag   <= s3_q.tag;
    end
  end

endmodule
